// File: rtl/gp_1to2_demux_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gp_pkg
// Purpose  : Shared definitions for the registered 1:2 stream demultiplexer:
//            per-output buffer occupancy encoding and destination select codes.
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package gp_pkg;

  // Occupancy of one output's 2-entry elastic buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Destination select encodings carried on in_sel.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : gp_pkg
`default_nettype wire

// File: rtl/gp_1to2_demux_reg_if.sv
`default_nettype none
// ============================================================================
// Interface: gp_1to2_demux_reg_if
// Purpose  : Bundles the input stream, both output streams and the optional
//            transfer counters of the 1:2 demultiplexer.
// Modports : slave  - demux view (consumes in_*, produces a_*/b_*/counts)
//            master - environment view (producer and both consumers)
// Revision : 1.0 - initial release
// ============================================================================
interface gp_1to2_demux_reg_if #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     in_data;
  logic                 in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_data;
  logic                 a_valid;
  logic                 a_ready;
  logic [WIDTH-1:0]     b_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [CNT_WIDTH-1:0] a_count;
  logic [CNT_WIDTH-1:0] b_count;

  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );
endinterface : gp_1to2_demux_reg_if
`default_nettype wire

// File: rtl/gp_1to2_demux_reg_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gp_skid_buffer
// Purpose  : 2-entry elastic buffer. The head register drives o_data; a skid
//            register behind it absorbs one extra word while the consumer
//            stalls.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            i_push, i_data   - write a word (caller guarantees not full)
//            i_ready          - consumer accepts the head word
//            o_data, o_valid  - head word and its valid
//            o_full           - both entries occupied
// Revision : 1.0 - initial release
// ============================================================================
module gp_skid_buffer
  import gp_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_ready,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_full
);

  occ_t             r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic             w_pop;

  // Ready is only meaningful while a word is presented.
  assign w_pop = (r_occ != OCC_EMPTY) && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= OCC_EMPTY;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_head <= i_data;
            r_occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (i_push && !w_pop) begin
            r_skid <= i_data;
            r_occ  <= OCC_TWO;
          end else if (w_pop && !i_push) begin
            r_occ  <= OCC_EMPTY;
          end else if (i_push && w_pop) begin
            // Head leaves and the new word replaces it; occupancy stays 1.
            r_head <= i_data;
          end
        end
        OCC_TWO: begin
          // No push can arrive here: the upstream ready is low while full.
          if (w_pop) begin
            r_head <= r_skid;
            r_occ  <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_occ != OCC_EMPTY);
  assign o_full  = (r_occ == OCC_TWO);

endmodule : gp_skid_buffer
`default_nettype wire

// File: rtl/gp_1to2_demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : gp_1to2_demux_reg
// Purpose  : Registered 1:2 stream demultiplexer. Each accepted input word is
//            routed to output A (in_sel=0) or B (in_sel=1), each output having
//            its own 2-entry elastic buffer. 1-cycle latency, 1 word/cycle.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - gp_1to2_demux_reg_if.slave (input stream, outputs A/B,
//                    transfer counters)
// Macros   : GP_DEMUX_STATS_EN - enables a_count/b_count output transfer
//                                counters; tied to 0 when undefined.
// Revision : 1.0 - initial release
// ============================================================================
module gp_1to2_demux_reg
  import gp_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 32
) (
  input wire logic         clk,
  input wire logic         rst_n,
  gp_1to2_demux_reg_if.slave bus
);

  logic r_run;
  logic w_full_a;
  logic w_full_b;
  logic w_accept;
  logic w_push_a;
  logic w_push_b;

  // Holds in_ready low during reset and lifts it on the first edge after
  // release, without any path from the handshake inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // A full buffer on either side stalls the input regardless of in_sel, so
  // ready never depends on the destination of the word being offered.
  assign bus.in_ready = r_run && !w_full_a && !w_full_b;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_push_a = w_accept && (bus.in_sel == SEL_A);
  assign w_push_b = w_accept && (bus.in_sel == SEL_B);

  gp_skid_buffer #(.WIDTH(WIDTH)) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_a),
    .i_data  (bus.in_data),
    .i_ready (bus.a_ready),
    .o_data  (bus.a_data),
    .o_valid (bus.a_valid),
    .o_full  (w_full_a)
  );

  gp_skid_buffer #(.WIDTH(WIDTH)) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_b),
    .i_data  (bus.in_data),
    .i_ready (bus.b_ready),
    .o_data  (bus.b_data),
    .o_valid (bus.b_valid),
    .o_full  (w_full_b)
  );

`ifdef GP_DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] r_cnt_a;
  logic [CNT_WIDTH-1:0] r_cnt_b;

  // Counters wrap naturally modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (bus.a_valid && bus.a_ready) r_cnt_a <= r_cnt_a + 1'b1;
      if (bus.b_valid && bus.b_ready) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  assign bus.a_count = r_cnt_a;
  assign bus.b_count = r_cnt_b;
`else
  assign bus.a_count = '0;
  assign bus.b_count = '0;
`endif

endmodule : gp_1to2_demux_reg
`default_nettype wire

// File: tb/tb_gp_1to2_demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_gp_1to2_demux_reg
// Purpose  : Self-checking bench for gp_1to2_demux_reg: directed vector table,
//            asynchronous reset mid-operation, counter wrap, and randomized
//            traffic against a queue-based reference model.
// Macros   : GP_DEMUX_STATS_EN - selects expected counter behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gp_1to2_demux_reg;

  localparam int WIDTH     = 64;
  localparam int CNT_WIDTH = 4;
`ifdef GP_DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;

  gp_1to2_demux_reg_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  gp_1to2_demux_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [63:0] d,
                       input logic ar, input logic br);
    bus.in_valid = iv;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;
    logic        sel;
    logic [63:0] d;
    logic        ar;
    logic        br;
    logic        eir;
    logic        eav;
    logic [63:0] ead;
    logic        ebv;
    logic [63:0] ebd;
  } vec_t;

  function automatic vec_t mk(logic iv, logic sel, logic [63:0] d, logic ar, logic br,
                              logic eir, logic eav, logic [63:0] ead,
                              logic ebv, logic [63:0] ebd);
    vec_t v;
    v.iv = iv; v.sel = sel; v.d = d; v.ar = ar; v.br = br;
    v.eir = eir; v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  bit          started;
  int          pops_a, pops_b, acc_words;
  bit          hold_a, hold_b;
  logic [63:0] last_a, last_b;

  function automatic logic [63:0] exp_cnt(int n);
    return STATS ? 64'(n % (1 << CNT_WIDTH)) : 64'd0;
  endfunction

  function automatic void model_clear();
    qa.delete();
    qb.delete();
    started = 1'b0;
    pops_a  = 0;
    pops_b  = 0;
    hold_a  = 1'b0;
    hold_b  = 1'b0;
  endfunction

  // Called just after a falling edge; drives, checks, steps one rising edge.
  task automatic model_step(input logic iv, input logic sel, input logic [63:0] d,
                            input logic ar, input logic br);
    bit exp_ir, pa, pb, acc;
    drive(iv, sel, d, ar, br);
    exp_ir = started && (qa.size() < 2) && (qb.size() < 2);
    chk("m_in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ir});
    chk("m_a_valid", {63'd0, bus.a_valid}, {63'd0, qa.size() != 0});
    chk("m_b_valid", {63'd0, bus.b_valid}, {63'd0, qb.size() != 0});
    if (qa.size() != 0) chk("m_a_data", bus.a_data, qa[0]);
    if (qb.size() != 0) chk("m_b_data", bus.b_data, qb[0]);
    if (hold_a) chk("a_data_stable", bus.a_data, last_a);
    if (hold_b) chk("b_data_stable", bus.b_data, last_b);
    chk("m_a_count", 64'(bus.a_count), exp_cnt(pops_a));
    chk("m_b_count", 64'(bus.b_count), exp_cnt(pops_b));
    pa  = (qa.size() != 0) && ar;
    pb  = (qb.size() != 0) && br;
    acc = iv && exp_ir;
    hold_a = (qa.size() != 0) && !ar;
    hold_b = (qb.size() != 0) && !br;
    last_a = bus.a_data;
    last_b = bus.b_data;
    @(posedge clk);
    if (pa) begin void'(qa.pop_front()); pops_a++; end
    if (pb) begin void'(qb.pop_front()); pops_b++; end
    if (acc) begin
      if (sel) qb.push_back(d);
      else     qa.push_back(d);
      acc_words++;
    end
    started = 1'b1;
    @(negedge clk);
  endtask

  vec_t vt[19];

  initial begin
    vt[0]  = mk(1, 0, 64'h11, 1, 1,  1, 1, 64'h11, 0, 64'h0);
    vt[1]  = mk(1, 0, 64'h22, 1, 1,  1, 1, 64'h22, 0, 64'h0);
    vt[2]  = mk(1, 0, 64'h33, 1, 1,  1, 1, 64'h33, 0, 64'h0);
    vt[3]  = mk(0, 0, 64'h0,  1, 1,  1, 0, 64'h0,  0, 64'h0);
    vt[4]  = mk(1, 0, 64'hA1, 0, 0,  1, 1, 64'hA1, 0, 64'h0);
    vt[5]  = mk(1, 0, 64'hA2, 0, 0,  0, 1, 64'hA1, 0, 64'h0);
    vt[6]  = mk(1, 1, 64'hB1, 0, 0,  0, 1, 64'hA1, 0, 64'h0);
    vt[7]  = mk(1, 1, 64'hB1, 1, 0,  1, 1, 64'hA2, 0, 64'h0);
    vt[8]  = mk(1, 1, 64'hB1, 1, 0,  1, 0, 64'h0,  1, 64'hB1);
    vt[9]  = mk(0, 0, 64'h0,  1, 1,  1, 0, 64'h0,  0, 64'h0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        vt[10+i] = mk(1, 0, 64'(i), 1, 1,  1, 1, 64'(i), 0, 64'h0);
      else
        vt[10+i] = mk(1, 1, 64'(i), 1, 1,  1, 0, 64'h0,  1, 64'(i));
    end
    vt[18] = mk(0, 0, 64'h0,  1, 1,  1, 0, 64'h0,  0, 64'h0);

    // ---- reset state ----
    rst_n = 1'b0;
    drive(0, 0, 64'h0, 0, 0);
    model_clear();
    acc_words = 0;
    #12;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_a_valid",  {63'd0, bus.a_valid},  64'd0);
    chk("rst_b_valid",  {63'd0, bus.b_valid},  64'd0);
    chk("rst_a_data",   bus.a_data, 64'd0);
    chk("rst_b_data",   bus.b_data, 64'd0);
    chk("rst_a_count",  64'(bus.a_count), 64'd0);
    chk("rst_b_count",  64'(bus.b_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // ---- directed table ----
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].iv, vt[i].sel, vt[i].d, vt[i].ar, vt[i].br);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {63'd0, bus.in_ready}, {63'd0, vt[i].eir});
      chk($sformatf("vec%0d_a_valid", i),  {63'd0, bus.a_valid},  {63'd0, vt[i].eav});
      chk($sformatf("vec%0d_b_valid", i),  {63'd0, bus.b_valid},  {63'd0, vt[i].ebv});
      if (vt[i].eav) chk($sformatf("vec%0d_a_data", i), bus.a_data, vt[i].ead);
      if (vt[i].ebv) chk($sformatf("vec%0d_b_data", i), bus.b_data, vt[i].ebd);
    end
    // Table delivered 9 words on A and 5 on B.
    chk("table_a_count", 64'(bus.a_count), exp_cnt(9));
    chk("table_b_count", 64'(bus.b_count), exp_cnt(5));

    // ---- asynchronous reset with buffered words ----
    @(negedge clk);
    model_clear();
    started = 1'b1;
    pops_a = 9;
    pops_b = 5;
    model_step(1, 0, 64'hC1, 0, 0);
    model_step(1, 1, 64'hD1, 0, 0);
    model_step(1, 0, 64'hC2, 0, 0);
    model_step(1, 1, 64'hD2, 0, 0);  // held off: A is full
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a_valid",  {63'd0, bus.a_valid},  64'd0);
    chk("async_rst_b_valid",  {63'd0, bus.b_valid},  64'd0);
    chk("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("async_rst_a_data",   bus.a_data, 64'd0);
    chk("async_rst_a_count",  64'(bus.a_count), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(0, 0, 64'h0, 1, 1);
    model_step(0, 0, 64'h0, 1, 1);
    model_step(0, 0, 64'h0, 1, 1);

    // ---- counter wrap: 17 words to A ----
    for (int i = 0; i < 17; i++) model_step(1, 0, 64'(100 + i), 1, 1);
    model_step(0, 0, 64'h0, 1, 1);
    model_step(0, 0, 64'h0, 1, 1);
    chk("wrap_a_count", 64'(bus.a_count), STATS ? 64'd1 : 64'd0);
    chk("wrap_b_count", 64'(bus.b_count), 64'd0);

    // ---- randomized traffic ----
    acc_words = 0;
    for (int c = 0; c < 20000 && acc_words < 1000; c++) begin
      model_step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("random_words_accepted", 64'(acc_words), 64'd1000);
    for (int c = 0; c < 8; c++) model_step(0, 0, 64'h0, 1, 1);
    chk("drain_a_valid", {63'd0, bus.a_valid}, 64'd0);
    chk("drain_b_valid", {63'd0, bus.b_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_gp_1to2_demux_reg
`default_nettype wire
